// File: rtl/alu_state_rx.sv
// alu_state_rx: receiver for the 3-wire ALU-state shift link; deserialises 56-bit frames into ALU fields.
// Optional macro ALU_RX_CHECK_EN adds an ALU recompute of the received frame and the CHECK_FAIL output.
module alu_state_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 S_CLK,
    input  logic                 S_DATA,
    input  logic                 S_RESET,
    output logic [15:0]          X,
    output logic [15:0]          Y,
    output logic [15:0]          OUT,
    output logic                 ZX,
    output logic                 NX,
    output logic                 ZY,
    output logic                 NY,
    output logic                 F,
    output logic                 NO,
    output logic                 NG,
    output logic                 ZR,
    output logic                 FRAME_VALID,
    output logic                 FRAME_ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT
`ifdef ALU_RX_CHECK_EN
    ,
    output logic                 CHECK_FAIL
`endif
);

    localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [5:0] LAST_BIT = 6'd55;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RECV = 2'd1,
        MARK = 2'd2
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [SYNC_STAGES-1:0] mark_sync;
    logic                   s_clk_q;
    logic                   s_clk_qq;
    logic [FLUSH_W-1:0]     flush_cnt;
    logic                   rise;
    logic                   bit_in;
    logic                   mark_in;

    logic [5:0]             bit_cnt, bit_cnt_n;
    logic [55:0]            shift_q;
    logic [55:0]            frame_q;
    logic [IDLE_W-1:0]      idle_cnt;
    logic                   timeout;
    logic                   shift_en;
    logic                   commit;
    logic                   err;
    logic                   frame_valid_q;
    logic                   frame_err_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    // Rises are suppressed until the synchroniser chain and the edge flop hold real pin
    // samples, so a link idling with S_CLK high does not look like a rise after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_sync  <= '0;
            data_sync <= '0;
            mark_sync <= '0;
            s_clk_qq  <= 1'b0;
            flush_cnt <= '0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], S_CLK};
            data_sync <= {data_sync[SYNC_STAGES-2:0], S_DATA};
            mark_sync <= {mark_sync[SYNC_STAGES-2:0], S_RESET};
            s_clk_qq  <= s_clk_q;
            if (flush_cnt != FLUSH_DONE) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign s_clk_q = clk_sync[SYNC_STAGES-1];
    assign bit_in  = data_sync[SYNC_STAGES-1];
    assign mark_in = mark_sync[SYNC_STAGES-1];
    assign rise    = s_clk_q & ~s_clk_qq & (flush_cnt == FLUSH_DONE);
    assign timeout = ~rise & (idle_cnt >= IDLE_MAX - 1'b1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= HUNT;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
        end
    end

    // A rise always takes precedence over the idle timeout, so an early marker landing
    // on the timeout cycle yields exactly one error.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_en  = 1'b0;
        commit    = 1'b0;
        err       = 1'b0;
        case (state)
            HUNT: begin
                if (rise && mark_in) begin
                    state_n   = RECV;
                    bit_cnt_n = '0;
                end
            end
            RECV: begin
                if (rise) begin
                    if (mark_in) begin
                        err       = 1'b1;
                        bit_cnt_n = '0;
                    end else begin
                        shift_en  = 1'b1;
                        bit_cnt_n = bit_cnt + 6'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state_n = MARK;
                        end
                    end
                end else if (timeout) begin
                    err       = 1'b1;
                    state_n   = HUNT;
                    bit_cnt_n = '0;
                end
            end
            MARK: begin
                if (rise) begin
                    bit_cnt_n = '0;
                    if (mark_in) begin
                        commit  = 1'b1;
                        state_n = RECV;
                    end else begin
                        err     = 1'b1;
                        state_n = HUNT;
                    end
                end else if (timeout) begin
                    err       = 1'b1;
                    state_n   = HUNT;
                    bit_cnt_n = '0;
                end
            end
            default: begin
                state_n   = HUNT;
                bit_cnt_n = '0;
            end
        endcase
    end

    // FRAME_VALID is a single-cycle strobe with no back-pressure: the field outputs change
    // only in the cycle FRAME_VALID is high and hold until the next strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_q       <= '0;
            frame_q       <= '0;
            idle_cnt      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            if (shift_en) begin
                shift_q <= {bit_in, shift_q[55:1]};
            end
            if (commit) begin
                frame_q <= shift_q;
            end
            if (rise) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            frame_valid_q <= commit;
            frame_err_q   <= err;
            if (err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign ZR          = frame_q[0];
    assign NG          = frame_q[1];
    assign NO          = frame_q[2];
    assign F           = frame_q[3];
    assign NY          = frame_q[4];
    assign ZY          = frame_q[5];
    assign NX          = frame_q[6];
    assign ZX          = frame_q[7];
    assign OUT         = frame_q[23:8];
    assign Y           = frame_q[39:24];
    assign X           = frame_q[55:40];
    assign FRAME_VALID = frame_valid_q;
    assign FRAME_ERR   = frame_err_q;
    assign ERR_CNT     = err_cnt_q;

`ifdef ALU_RX_CHECK_EN
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [15:0] alu_sum;
    logic [15:0] alu_out;
    logic        alu_ng;
    logic        alu_zr;
    logic        check_fail_q;

    // Recompute from the shift register, which holds the complete frame while in MARK.
    always_comb begin
        alu_x   = shift_q[7] ? 16'h0000 : shift_q[55:40];
        alu_x   = shift_q[6] ? ~alu_x : alu_x;
        alu_y   = shift_q[5] ? 16'h0000 : shift_q[39:24];
        alu_y   = shift_q[4] ? ~alu_y : alu_y;
        alu_sum = shift_q[3] ? (alu_x + alu_y) : (alu_x & alu_y);
        alu_out = shift_q[2] ? ~alu_sum : alu_sum;
        alu_ng  = alu_out[15];
        alu_zr  = (alu_out == 16'h0000);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            check_fail_q <= 1'b0;
        end else if (commit) begin
            check_fail_q <= (alu_out != shift_q[23:8]) | (alu_ng != shift_q[1]) |
                            (alu_zr != shift_q[0]);
        end
    end

    assign CHECK_FAIL = check_fail_q;
`endif

endmodule

// File: tb/tb_alu_state_rx.sv
// tb_alu_state_rx: drives the ALU-state link from a bench transmitter and scoreboards committed frames.
// Build with ALU_RX_CHECK_EN defined to also score CHECK_FAIL.
module tb_alu_state_rx;

    localparam int HALF     = 4;    // S_CLK half period in CLK cycles (link at CLK/8)
    localparam int N_RANDOM = 100;

    logic        CLK;
    logic        RST;
    logic        S_CLK;
    logic        S_DATA;
    logic        S_RESET;
    logic [15:0] X;
    logic [15:0] Y;
    logic [15:0] OUT;
    logic        ZX, NX, ZY, NY, F, NO, NG, ZR;
    logic        FRAME_VALID;
    logic        FRAME_ERR;
    logic [7:0]  ERR_CNT;
`ifdef ALU_RX_CHECK_EN
    logic        CHECK_FAIL;
`endif

    alu_state_rx dut (
        .CLK(CLK), .RST(RST), .S_CLK(S_CLK), .S_DATA(S_DATA), .S_RESET(S_RESET),
        .X(X), .Y(Y), .OUT(OUT),
        .ZX(ZX), .NX(NX), .ZY(ZY), .NY(NY), .F(F), .NO(NO), .NG(NG), .ZR(ZR),
        .FRAME_VALID(FRAME_VALID), .FRAME_ERR(FRAME_ERR), .ERR_CNT(ERR_CNT)
`ifdef ALU_RX_CHECK_EN
        , .CHECK_FAIL(CHECK_FAIL)
`endif
    );

    // clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int err_seen = 0;
    int valid_seen = 0;
    int pushed = 0;
    int exp_err_pulses = 0;
    int exp_err_cnt = 0;
    logic [55:0] exp_q[$];
    logic        chk_q[$];
    logic [55:0] last_frame = '0;

    wire [55:0] obs = {X, Y, OUT, ZX, NX, ZY, NY, F, NO, NG, ZR};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: frame assembly and the Hack-style ALU
    function automatic logic [55:0] mk(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] o, input logic [5:0] ctl,
                                       input logic ng, input logic zr);
        return {x, y, o, ctl, ng, zr};
    endfunction

    function automatic logic [15:0] alu(input logic [15:0] x, input logic [15:0] y,
                                        input logic [5:0] ctl);
        logic [15:0] a, b, r;
        a = ctl[5] ? 16'd0 : x;
        if (ctl[4]) a = ~a;
        b = ctl[3] ? 16'd0 : y;
        if (ctl[2]) b = ~b;
        r = ctl[1] ? 16'(a + b) : (a & b);
        if (ctl[0]) r = ~r;
        return r;
    endfunction

    function automatic logic chk_model(input logic [55:0] fr);
        logic [15:0] r;
        r = alu(fr[55:40], fr[39:24], fr[7:2]);
        return (r != fr[23:8]) || (r[15] != fr[1]) || ((r == 16'd0) != fr[0]);
    endfunction

    function automatic logic [55:0] mk_consistent(input logic [15:0] x, input logic [15:0] y,
                                                  input logic [5:0] ctl);
        logic [15:0] r;
        r = alu(x, y, ctl);
        return mk(x, y, r, ctl, r[15], r == 16'd0);
    endfunction

    // driver tasks: data changes with the S_CLK fall, receiver samples on the rise
    task automatic tx_bit(input logic d, input logic m);
        S_CLK   = 1'b0;
        S_DATA  = d;
        S_RESET = m;
        repeat (HALF) @(negedge CLK);
        S_CLK = 1'b1;
        repeat (HALF) @(negedge CLK);
    endtask

    task automatic tx_range(input logic [55:0] fr, input int lo, input int hi);
        for (int i = lo; i < hi; i++) tx_bit(fr[i], 1'b0);
    endtask

    task automatic tx_marker();
        tx_bit(1'b0, 1'b1);
    endtask

    task automatic tx_good(input logic [55:0] fr);
        tx_range(fr, 0, 56);
        exp_q.push_back(fr);
        chk_q.push_back(chk_model(fr));
        pushed++;
        tx_marker();
    endtask

    function automatic logic [55:0] rnd56();
        return 56'({$urandom(), $urandom()});
    endfunction

    // monitor / scoreboard
    always @(negedge CLK) begin
        logic [55:0] e;
        logic        c;
        if (FRAME_ERR) err_seen++;
        if (FRAME_VALID) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got frame %h expected none", obs);
            end else begin
                e = exp_q.pop_front();
                c = chk_q.pop_front();
                check("frame_fields", 64'(obs), 64'(e));
`ifdef ALU_RX_CHECK_EN
                check("check_fail", 64'(CHECK_FAIL), 64'(c));
`endif
                last_frame = e;
            end
        end
    end

    task automatic check_errs(input string name);
        check({name, "_pulses"}, 64'(err_seen), 64'(exp_err_pulses));
        check({name, "_cnt"}, 64'(ERR_CNT), 64'(exp_err_cnt));
    endtask

    initial begin
        logic [55:0] fr;
        RST = 1'b1; S_CLK = 1'b0; S_DATA = 1'b0; S_RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_fields", 64'(obs), 64'd0);
        check("reset_err_cnt", 64'(ERR_CNT), 64'd0);
        check("reset_strobes", 64'({FRAME_VALID, FRAME_ERR}), 64'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // two good frames; the first marker only starts reception
        tx_marker();
        check("first_marker_fields", 64'(obs), 64'd0);
        check("first_marker_valid", 64'(valid_seen), 64'd0);
        tx_good(mk(16'h1234, 16'h00FF, 16'hFFFF, 6'b011111, 1'b1, 1'b0));
        check("a_valid_count", 64'(valid_seen), 64'd1);
        check("a_x", 64'(X), 64'h1234);
        check("a_y", 64'(Y), 64'h00FF);
        check("a_out", 64'(OUT), 64'hFFFF);
        check("a_ctl", 64'({ZX, NX, ZY, NY, F, NO}), 64'b011111);
        check("a_flags", 64'({NG, ZR}), 64'b10);
        check_errs("a_err");
        tx_good(rnd56());

        // early marker after 30 bits
        tx_range(rnd56(), 0, 30);
        tx_marker();
        exp_err_pulses++; exp_err_cnt++;
        check_errs("short_err");
        check("short_hold", 64'(obs), 64'(last_frame));
        tx_good(rnd56());

        // overlong frame: 57 data bits
        fr = rnd56();
        tx_range(fr, 0, 56);
        tx_bit(1'($urandom_range(0, 1)), 1'b0);
        exp_err_pulses++; exp_err_cnt++;
        check_errs("long_err");
        check("long_hold", 64'(obs), 64'(last_frame));
        tx_marker();
        tx_good(rnd56());

        // S_CLK stalls at bit 20
        fr = rnd56();
        tx_range(fr, 0, 20);
        repeat (4000) @(negedge CLK);
        check_errs("timeout_early");
        repeat (1000) @(negedge CLK);
        exp_err_pulses++; exp_err_cnt++;
        check_errs("timeout_err");
        check("timeout_hold", 64'(obs), 64'(last_frame));
        tx_range(fr, 20, 56);
        tx_marker();
        tx_good(rnd56());

        // reset at bit 40
        fr = rnd56();
        tx_range(fr, 0, 40);
        RST = 1'b1;
        @(negedge CLK);
        check("midreset_fields", 64'(obs), 64'd0);
        check("midreset_err_cnt", 64'(ERR_CNT), 64'd0);
        RST = 1'b0;
        exp_err_cnt = 0;
        tx_range(fr, 40, 56);
        tx_marker();
        tx_good(rnd56());
        check_errs("post_reset");

        // ALU consistency frames (x+y)
        tx_good(mk(16'd5, 16'd3, 16'd8, 6'b000010, 1'b0, 1'b0));
        tx_good(mk(16'd5, 16'd3, 16'd9, 6'b000010, 1'b0, 1'b0));

        // back-to-back random frames
        for (int k = 0; k < N_RANDOM; k++) begin
            if (k % 2 == 0)
                tx_good(mk_consistent(16'($urandom()), 16'($urandom()),
                                      6'($urandom_range(0, 63))));
            else
                tx_good(rnd56());
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge CLK);
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        check("valid_total", 64'(valid_seen), 64'(pushed));
        check_errs("final_err");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
